// File: rtl/decoder_3to8_seq.sv
// Sequential 3-to-8 one-hot decoder with programmable hold time and a one-entry pending buffer.
// Optional macro DECODER_PARITY_EN adds an even-parity check on incoming codes.
module decoder_3to8_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] code_in,
    input  logic       code_valid,
`ifdef DECODER_PARITY_EN
    input  logic       code_par,
    output logic       par_err,
`endif
    output logic       code_ready,
    output logic [7:0] y,
    output logic       y_valid,
    output logic       done
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       code_q;
    logic [2:0]       pend_q;
    logic             pend_full_q;

    logic xfer;
    logic par_ok;
    logic accept;
    logic active;

`ifdef DECODER_PARITY_EN
    logic par_err_q;

    // Even parity: the XOR over {code_par, code_in} must be zero.
    assign par_ok = ~^{code_par, code_in};

    always_ff @(posedge clk) begin
        if (reset) par_err_q <= 1'b0;
        else       par_err_q <= xfer && !par_ok;
    end

    assign par_err = par_err_q;
`else
    assign par_ok = 1'b1;
`endif

    assign code_ready = enable && !reset && !pend_full_q;
    assign xfer       = code_valid && code_ready;
    assign accept     = xfer && par_ok;

    assign active  = enable && (state_q == HOLD);
    assign y       = active ? (8'b1 << code_q) : 8'h00;
    assign y_valid = active;
    assign done    = active && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_full_q <= 1'b0;
        end else if (enable) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        code_q  <= code_in;
                        cnt_q   <= CNT_LOAD;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (accept) begin
                            pend_q      <= code_in;
                            pend_full_q <= 1'b1;
                        end
                    end else if (pend_full_q) begin
                        code_q      <= pend_q;
                        cnt_q       <= CNT_LOAD;
                        pend_full_q <= 1'b0;
                    end else if (accept) begin
                        // Bypass: a code arriving on the last hold cycle goes straight to y.
                        code_q <= code_in;
                        cnt_q  <= CNT_LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
